// File: rtl/jstk2_pkg.sv
// ---------------------------------------------------------------------------
// jstk2_pkg
// Shared definitions for the joystick poll scheduler: sample width, the
// servo centre value and the scheduler FSM state encoding.
// ---------------------------------------------------------------------------
package jstk2_pkg;

    localparam int                JSTK_W = 10;
    localparam logic [JSTK_W-1:0] CENTER = 10'd512;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        START,
        WAIT_DONE,
        UPDATE
    } state_t;

endpackage

// File: rtl/slew_limiter.sv
// ---------------------------------------------------------------------------
// slew_limiter
// Moves one servo axis from its current value toward a target. The step is
// limited to at most SLEW_STEP codes per update.
//   i_target  : requested position (0..1023)
//   i_current : position currently driven
//   o_next    : next position. It always stays between i_current and
//               i_target, so it cannot leave 0..1023.
// ---------------------------------------------------------------------------
module slew_limiter
    import jstk2_pkg::*;
#(
    parameter int SLEW_STEP = 4
) (
    input  logic [JSTK_W-1:0] i_target,
    input  logic [JSTK_W-1:0] i_current,
    output logic [JSTK_W-1:0] o_next
);

    localparam logic        [JSTK_W-1:0] STEP_U = JSTK_W'(SLEW_STEP);
    localparam logic signed [JSTK_W:0]   STEP_S = (JSTK_W+1)'(SLEW_STEP);

    // One extra bit holds the full -1023..+1023 range of target - current.
    logic signed [JSTK_W:0] w_diff;

    assign w_diff = $signed({1'b0, i_target}) - $signed({1'b0, i_current});

    // NOTE: every branch assigns o_next, so this block stays combinational and no latch is inferred.
    always_comb begin
        if (w_diff > STEP_S) begin
            o_next = i_current + STEP_U;
        end else if (w_diff < -STEP_S) begin
            o_next = i_current - STEP_U;
        end else begin
            o_next = i_target;
        end
    end

endmodule

// File: rtl/jstk2_poll_scheduler.sv
// ---------------------------------------------------------------------------
// jstk2_poll_scheduler
// Polls a JSTK2 joystick over an SPI front end at a fixed rate and turns each
// sample into slew-limited servo commands. The block counts transactions that
// time out. After MAX_MISS timeouts in a row it flags the data as stale and
// steers both axes back to centre.
//   clk         : sole clock, rising edge
//   rst         : asynchronous active-low reset
//   enable      : polling allowed while high
//   spi_busy    : SPI front end is busy and cannot accept a request
//   spi_done    : one-cycle pulse; x_raw/y_raw are valid in that cycle
//   x_raw/y_raw : raw joystick samples
//   spi_start   : one-cycle transaction request
//   x_val/y_val : slew-limited servo commands
//   upd         : one-cycle pulse when x_val/y_val are written
//   timeout_err : one-cycle pulse when a transaction times out
//   stale       : level; MAX_MISS consecutive timeouts reached
// ---------------------------------------------------------------------------
module jstk2_poll_scheduler
    import jstk2_pkg::*;
#(
    parameter int POLL_DIV    = 1_000_000,
    parameter int TIMEOUT_CYC = 50_000,
    parameter int SLEW_STEP   = 4,
    parameter int MAX_MISS    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              spi_busy,
    input  logic              spi_done,
    input  logic [JSTK_W-1:0] x_raw,
    input  logic [JSTK_W-1:0] y_raw,
    output logic              spi_start,
    output logic [JSTK_W-1:0] x_val,
    output logic [JSTK_W-1:0] y_val,
    output logic              upd,
    output logic              timeout_err,
    output logic              stale
);

    localparam int TICK_W = $clog2(POLL_DIV + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam int MISS_W = $clog2(MAX_MISS + 1);

    state_t              r_state;
    logic [TICK_W-1:0]   r_tick;
    logic [TO_W-1:0]     r_to_cnt;
    logic [MISS_W-1:0]   r_miss;
    logic [JSTK_W-1:0]   r_tgt_x;
    logic [JSTK_W-1:0]   r_tgt_y;
    logic [JSTK_W-1:0]   r_x_val;
    logic [JSTK_W-1:0]   r_y_val;
    logic                r_spi_start;
    logic                r_upd;
    logic                r_timeout_err;
    logic                r_stale;

    logic                w_tick;
    logic                w_timeout;
    logic [MISS_W-1:0]   w_miss_next;
    logic [JSTK_W-1:0]   w_x_next;
    logic [JSTK_W-1:0]   w_y_next;

    assign w_tick      = (r_tick == TICK_W'(POLL_DIV - 1));
    assign w_timeout   = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign w_miss_next = (r_miss == MISS_W'(MAX_MISS)) ? r_miss : r_miss + MISS_W'(1);

    slew_limiter #(.SLEW_STEP(SLEW_STEP)) u_slew_x (
        .i_target  (r_tgt_x),
        .i_current (r_x_val),
        .o_next    (w_x_next)
    );

    slew_limiter #(.SLEW_STEP(SLEW_STEP)) u_slew_y (
        .i_target  (r_tgt_y),
        .i_current (r_y_val),
        .o_next    (w_y_next)
    );

    // The poll-rate counter runs freely while polling is enabled. A START
    // that is held up by spi_busy therefore does not shift later polls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tick <= '0;
        end else if (!enable || w_tick) begin
            r_tick <= '0;
        end else begin
            r_tick <= r_tick + TICK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_to_cnt      <= '0;
            r_miss        <= '0;
            r_tgt_x       <= CENTER;
            r_tgt_y       <= CENTER;
            r_x_val       <= CENTER;
            r_y_val       <= CENTER;
            r_spi_start   <= 1'b0;
            r_upd         <= 1'b0;
            r_timeout_err <= 1'b0;
            r_stale       <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults; a pulse stays high only when a branch below re-asserts it this cycle.
            r_spi_start   <= 1'b0;
            r_upd         <= 1'b0;
            r_timeout_err <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (enable) r_state <= WAIT_TICK;
                end

                WAIT_TICK: begin
                    if (!enable) begin
                        r_state <= IDLE;
                    end else if (w_tick) begin
                        r_state  <= START;
                        r_to_cnt <= '0;
                    end
                end

                // A single timeout window covers the wait for the bus and
                // the transaction itself.
                START, WAIT_DONE: begin
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                    if (r_state == WAIT_DONE && spi_done) begin
                        // A done pulse wins over a timeout that expires in the same cycle.
                        r_tgt_x <= x_raw;
                        r_tgt_y <= y_raw;
                        r_miss  <= '0;
                        r_stale <= 1'b0;
                        r_state <= UPDATE;
                    end else if (r_state == START && !enable) begin
                        r_state <= IDLE;
                    end else if (w_timeout) begin
                        // Checked before issuing a request. A request made in
                        // the last cycle would leave no time for its done pulse.
                        r_timeout_err <= 1'b1;
                        r_miss        <= w_miss_next;
                        if (w_miss_next == MISS_W'(MAX_MISS)) begin
                            r_stale <= 1'b1;
                            r_tgt_x <= CENTER;
                            r_tgt_y <= CENTER;
                            r_state <= UPDATE;
                        end else begin
                            r_state <= enable ? WAIT_TICK : IDLE;
                        end
                    end else if (r_state == START && !spi_busy) begin
                        r_spi_start <= 1'b1;
                        r_state     <= WAIT_DONE;
                    end
                end

                UPDATE: begin
                    r_x_val <= w_x_next;
                    r_y_val <= w_y_next;
                    r_upd   <= 1'b1;
                    r_state <= enable ? WAIT_TICK : IDLE;
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign spi_start   = r_spi_start;
    assign x_val       = r_x_val;
    assign y_val       = r_y_val;
    assign upd         = r_upd;
    assign timeout_err = r_timeout_err;
    assign stale       = r_stale;

endmodule

// File: tb/tb_jstk2_poll_scheduler.sv
// ---------------------------------------------------------------------------
// tb_jstk2_poll_scheduler
// Directed bench for jstk2_poll_scheduler with POLL_DIV=100, TIMEOUT_CYC=40,
// SLEW_STEP=4, MAX_MISS=3. Inputs change and outputs are sampled on the
// falling edge. Negedge k after a reference point lies between rising edges
// k and k+1.
//
// Timing used throughout:
// - After reset release the tick wraps on the 100th rising edge and START is
//   entered there. START issues the request on the 101st edge, so spi_start
//   shows at negedge 101.
// - In the cycle spi_start is visible the timeout count is 1. The count
//   reaches 39 (the timeout cycle) 38 negedges later, and timeout_err shows
//   at negedge 39.
// - A done pulse driven at negedge k gives upd and the new values at
//   negedge k+2.
// ---------------------------------------------------------------------------
module tb_jstk2_poll_scheduler;

    localparam int POLL_DIV    = 100;
    localparam int TIMEOUT_CYC = 40;
    localparam int SLEW_STEP   = 4;
    localparam int MAX_MISS    = 3;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       enable   = 1'b0;
    logic       spi_busy = 1'b0;
    logic       spi_done = 1'b0;
    logic [9:0] x_raw    = '0;
    logic [9:0] y_raw    = '0;
    logic       spi_start;
    logic [9:0] x_val;
    logic [9:0] y_val;
    logic       upd;
    logic       timeout_err;
    logic       stale;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [9:0] xr;
        logic [9:0] yr;
        logic [9:0] ex;
        logic [9:0] ey;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    jstk2_poll_scheduler #(
        .POLL_DIV    (POLL_DIV),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .SLEW_STEP   (SLEW_STEP),
        .MAX_MISS    (MAX_MISS)
    ) dut (
        .clk         (clk),
        .rst         (rst_n),
        .enable      (enable),
        .spi_busy    (spi_busy),
        .spi_done    (spi_done),
        .x_raw       (x_raw),
        .y_raw       (y_raw),
        .spi_start   (spi_start),
        .x_val       (x_val),
        .y_val       (y_val),
        .upd         (upd),
        .timeout_err (timeout_err),
        .stale       (stale)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Waits for spi_start, at most max_cyc negedges. Returns the number of
    // negedges taken, or -1 if the wait ran out. Also counts upd pulses and
    // off-centre samples seen while waiting.
    task automatic wait_start(input int max_cyc, output int n, output int upd_cnt, output int off_ctr);
        n       = 0;
        upd_cnt = 0;
        off_ctr = 0;
        forever begin
            @(negedge clk);
            n++;
            if (upd) upd_cnt++;
            if (x_val != 10'd512 || y_val != 10'd512) off_ctr++;
            if (spi_start) break;
            if (n >= max_cyc) begin
                n = -1;
                break;
            end
        end
    endtask

    task automatic next_poll(input string name, input int exp_n);
        int n, u, o;
        wait_start(200, n, u, o);
        check(name, n, exp_n);
    endtask

    // Called at the negedge where spi_start is seen. Lets the transaction
    // time out, then checks the cycle after timeout_err.
    task automatic do_timeout(input string tag, input logic exp_stale, input logic exp_upd,
                              input logic [9:0] ex, input logic [9:0] ey);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!timeout_err && n < 60);
        check({tag, "_err_delay"}, n, 39);
        check({tag, "_stale"}, stale, exp_stale);
        @(negedge clk);
        check({tag, "_err_width"}, timeout_err, 0);
        check({tag, "_upd"}, upd, exp_upd);
        check({tag, "_x"}, x_val, ex);
        check({tag, "_y"}, y_val, ey);
    endtask

    initial begin
        int n, u, o, cnt;

        vecs[0] = '{10'd520,  10'd510,  10'd516, 10'd510};
        vecs[1] = '{10'd520,  10'd510,  10'd520, 10'd510};
        vecs[2] = '{10'd1023, 10'd0,    10'd524, 10'd506};
        vecs[3] = '{10'd1023, 10'd0,    10'd528, 10'd502};
        vecs[4] = '{10'd524,  10'd506,  10'd524, 10'd506};
        vecs[5] = '{10'd529,  10'd501,  10'd528, 10'd502};
        vecs[6] = '{10'd527,  10'd503,  10'd527, 10'd503};
        vecs[7] = '{10'd0,    10'd1023, 10'd523, 10'd507};

        // Reset state.
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_spi_start", spi_start, 0);
        check("rst_upd", upd, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_stale", stale, 0);
        check("rst_x_val", x_val, 512);
        check("rst_y_val", y_val, 512);

        // First poll after reset release.
        rst_n = 1'b1;
        wait_start(200, n, u, o);
        check("first_start_delay", n, 101);
        check("no_upd_before_first", u, 0);
        check("centre_before_first", o, 0);

        // Slew table: one poll per entry, done returned promptly.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("v%0d_start_width", i), spi_start, 0);
            @(negedge clk);
            spi_done = 1'b1;
            x_raw    = vecs[i].xr;
            y_raw    = vecs[i].yr;
            @(negedge clk);
            spi_done = 1'b0;
            x_raw    = 10'd0;
            y_raw    = 10'd0;
            check($sformatf("v%0d_upd_early", i), upd, 0);
            @(negedge clk);
            check($sformatf("v%0d_upd", i), upd, 1);
            check($sformatf("v%0d_x", i), x_val, vecs[i].ex);
            check($sformatf("v%0d_y", i), y_val, vecs[i].ey);
            @(negedge clk);
            check($sformatf("v%0d_upd_width", i), upd, 0);
            next_poll($sformatf("v%0d_period", i), 95);
        end

        // Three misses in a row go stale and step toward centre, and a
        // fourth miss keeps stepping.
        do_timeout("to1", 1'b0, 1'b0, 10'd523, 10'd507);
        next_poll("to1_period", 60);
        do_timeout("to2", 1'b0, 1'b0, 10'd523, 10'd507);
        next_poll("to2_period", 60);
        do_timeout("to3", 1'b1, 1'b1, 10'd519, 10'd511);
        next_poll("to3_period", 60);
        do_timeout("to4", 1'b1, 1'b1, 10'd515, 10'd512);
        next_poll("to4_period", 60);

        // Done in the very cycle the timeout expires: done wins.
        repeat (38) @(negedge clk);
        spi_done = 1'b1;
        x_raw    = 10'd530;
        y_raw    = 10'd500;
        @(negedge clk);
        spi_done = 1'b0;
        check("coinc_no_err", timeout_err, 0);
        check("coinc_upd_early", upd, 0);
        @(negedge clk);
        check("coinc_upd", upd, 1);
        check("coinc_x", x_val, 519);
        check("coinc_y", y_val, 508);
        check("coinc_stale_clr", stale, 0);
        next_poll("coinc_period", 60);
        // The miss counter is back to 0, so one miss must not go stale.
        do_timeout("to5", 1'b0, 1'b0, 10'd519, 10'd508);
        next_poll("to5_period", 60);

        // spi_busy held across the next START for 10 cycles.
        spi_busy = 1'b1;
        @(negedge clk);
        spi_done = 1'b1;
        x_raw    = 10'd600;
        y_raw    = 10'd400;
        @(negedge clk);
        spi_done = 1'b0;
        @(negedge clk);
        check("busy_txn_upd", upd, 1);
        check("busy_txn_x", x_val, 523);
        check("busy_txn_y", y_val, 504);
        cnt = 0;
        for (int k = 4; k <= 109; k++) begin
            @(negedge clk);
            if (spi_start) cnt++;
        end
        check("busy_no_start", cnt, 0);
        spi_busy = 1'b0;
        @(negedge clk);
        check("busy_release_start", spi_start, 1);
        @(negedge clk);
        check("busy_start_width", spi_start, 0);

        // Reset while in WAIT_DONE, then a late done pulse.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_spi_start", spi_start, 0);
        check("midrst_upd", upd, 0);
        check("midrst_timeout_err", timeout_err, 0);
        check("midrst_stale", stale, 0);
        check("midrst_x", x_val, 512);
        check("midrst_y", y_val, 512);
        spi_done = 1'b1;
        x_raw    = 10'd700;
        y_raw    = 10'd300;
        @(negedge clk);
        spi_done = 1'b0;
        rst_n    = 1'b1;
        cnt = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            spi_done = (k == 1);
            if (upd || timeout_err || spi_start) cnt++;
        end
        spi_done = 1'b0;
        check("midrst_quiet", cnt, 0);
        check("midrst_x_hold", x_val, 512);
        check("midrst_y_hold", y_val, 512);
        @(negedge clk);
        check("midrst_restart", spi_start, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Backstop so a stuck run still ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
